apb_cmd_master: RTL
===================

# apb_cmd_master

APB requester that turns a simple valid/ready command stream into single APB transfers (SETUP then ACCESS) toward the EX_CON/EX_TO register slave and any other APB peripherals on the bus. It registers all APB outputs, waits on PREADY, aborts hung transfers after a programmable timeout, and returns one response per command. It sits between the system controller and the APB segment, at the opposite end of the bus from the register slaves.

## Interface
- ADDR_W, 5, PADDR width
- DATA_W, 32, PWDATA/PRDATA width
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
- SYSCLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- CMD_VALID  in  1  command present
- CMD_READY  out  1  block can accept a command
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  ADDR_W  target register address
- CMD_WDATA  in  DATA_W  write data (ignored on reads)
- RSP_VALID  out  1  one-cycle pulse, transfer finished
- RSP_RDATA  out  DATA_W  read data (0 for writes and errors)
- RSP_ERR  out  1  1 = timed out, valid with RSP_VALID
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready; tie 1 for zero-wait slaves

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: CMD_READY=1. On CMD_VALID&&CMD_READY, latch CMD_WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA (PWDATA=0 on reads); go SETUP.
- SETUP: PSEL=1, PENABLE=0, CMD_READY=0; unconditionally go ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stable through SETUP and ACCESS.
  - PREADY=1 at edge: capture PRDATA into RSP_RDATA (reads) or 0 (writes), RSP_ERR=0, pulse RSP_VALID, go IDLE.
  - PREADY=0: increment wait counter (width clog2(TIMEOUT+1), saturating). When counter reaches TIMEOUT (TIMEOUT!=0) and PREADY still 0: abort, RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0, go IDLE.
  - PREADY=1 in the same cycle the timeout would fire: normal completion wins.
- Wait counter clears on entry to SETUP.
- Responses are not backpressured; consumer must take RSP_* on the RSP_VALID cycle. RSP_RDATA/RSP_ERR hold until next response.
- Exactly one response per accepted command; no commands accepted while a transfer is in flight.
- After completion, PSEL/PENABLE drop to 0; PADDR/PWRITE/PWDATA hold last values until next accept.
- Reset values: state IDLE, CMD_READY=0 during reset cycle then 1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, counter 0.
- Reset mid-transfer: at the next edge with RST=1 all of the above apply; in-flight command dropped, no response issued.

## Timing
- Cycle 0: command handshake in IDLE. Cycle 1: SETUP. Cycle 2: first ACCESS cycle.
- Zero-wait transfer: RSP_VALID high in cycle 3; CMD_READY high again in cycle 3 → max throughput one transfer per 3 cycles.
- N wait states: RSP_VALID in cycle 3+N.
- Timeout: abort response in cycle 2+TIMEOUT, PSEL/PENABLE low same cycle.
- All outputs registered; no combinational path from PRDATA/PREADY or CMD_* to any output.

## Test plan
- Write: cmd write addr 0x01 data 0x0000_00FF, PREADY=1 -> PSEL 1 cycles 1–2, PENABLE 1 cycle 2 only, PADDR=0x01, PWDATA=0xFF, PWRITE=1; RSP_VALID cycle 3, RSP_ERR=0, RSP_RDATA=0.
- Read: cmd read addr 0x00, slave PRDATA=0xA5A5_0003 in ACCESS -> RSP_VALID cycle 3, RSP_RDATA=0xA5A5_0003, PWDATA=0, PWRITE=0.
- Wait states: PREADY low 3 ACCESS cycles then high, PRDATA=0x1234_5678 -> PENABLE high 4 cycles, RSP_VALID cycle 6, RSP_RDATA=0x1234_5678, RSP_ERR=0.
- Timeout: TIMEOUT=4, PREADY held 0 -> abort cycle 6, RSP_ERR=1, RSP_RDATA=0, PSEL=0; PREADY rising exactly on the firing cycle instead -> normal completion, RSP_ERR=0.
- Back-to-back: CMD_VALID held with write 0x01/0x10 then read 0x01 -> second accept in cycle 3, PSEL low for exactly cycle 3, two responses at cycles 3 and 6.
- Reset: RST=1 during ACCESS with PREADY=0 -> next edge PSEL=PENABLE=0, all outputs at reset values, no RSP_VALID; new command after release completes normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master
// Purpose  : Turns a valid/ready command stream into single APB transfers,
//            with a PREADY wait timeout and one response per command.
// Revision : 1.0  initial release
// ============================================================================
module apb_cmd_master #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              SYSCLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the TIMEOUT-th low-PREADY ACCESS cycle, i.e. when the
    // count of earlier wait cycles equals TIMEOUT-1.
    localparam logic [CNT_W-1:0] c_cnt_last = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (CMD_VALID && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_pwrite    <= CMD_WRITE;
                        r_paddr     <= CMD_ADDR;
                        r_pwdata    <= CMD_WRITE ? CMD_WDATA : '0;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                        r_rsp_err   <= 1'b0;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if ((TIMEOUT != 0) && (r_cnt == c_cnt_last)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_cmd_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY = r_cmd_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rsp_rdata;
    assign RSP_ERR   = r_rsp_err;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

endmodule
`default_nettype wire
